// File: rtl/grf_scoreboard_pkg.sv
// Shared CPU constants for the GRF hazard scoreboard: register count, pipeline lifetime
// and the forwarding-latency clamp.
package grf_scoreboard_pkg;

  localparam int unsigned GRF_NREG      = 32;
  localparam int unsigned GRF_AW        = 5;
  localparam int unsigned GRF_CNT_W     = 6;
  localparam int unsigned GRF_LIFE_INIT = 3;
  localparam int unsigned GRF_TNEW_MAX  = 2;

  // A result is forwardable from W at the latest, so tnew never needs to exceed 2.
  function automatic logic [1:0] clamp_tnew(input logic [1:0] t);
    return (t > 2'(GRF_TNEW_MAX)) ? 2'(GRF_TNEW_MAX) : t;
  endfunction

endpackage

// File: rtl/grf_scoreboard_if.sv
// D-stage issue/read bundle between the decoder (master) and the scoreboard (slave).
interface grf_scoreboard_if;
  import grf_scoreboard_pkg::*;

  logic                   IssueEn;
  logic                   IssueWr;
  logic [GRF_AW-1:0]      IssueA3;
  logic [1:0]             IssueTnew;
  logic [GRF_AW-1:0]      A1;
  logic [GRF_AW-1:0]      A2;
  logic [1:0]             Tuse1;
  logic [1:0]             Tuse2;
  logic                   Use1;
  logic                   Use2;
  logic                   Flush;
  logic                   Stall;
  logic [GRF_NREG-1:0]    Busy;
  logic [GRF_CNT_W-1:0]   BusyCnt;

  modport master (
    output IssueEn, IssueWr, IssueA3, IssueTnew, A1, A2, Tuse1, Tuse2, Use1, Use2, Flush,
    input  Stall, Busy, BusyCnt
  );

  modport slave (
    input  IssueEn, IssueWr, IssueA3, IssueTnew, A1, A2, Tuse1, Tuse2, Use1, Use2, Flush,
    output Stall, Busy, BusyCnt
  );

endinterface

// File: rtl/grf_sb_entry.sv
// One scoreboard cell: tracks a single in-flight writer of one GRF register through E/M/W,
// counting down its remaining lifetime and cycles until the result is forwardable.
module grf_sb_entry
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned LIFE_INIT = GRF_LIFE_INIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       load,
  input  logic [1:0] load_tnew,
  output logic       valid,
  output logic [1:0] tnew
);

  logic       valid_q = 1'b0;
  logic [1:0] tnew_q  = 2'd0;
  logic [1:0] life_q  = 2'd0;
  logic       valid_d;
  logic [1:0] tnew_d;
  logic [1:0] life_d;

  always_comb begin
    valid_d = valid_q;
    tnew_d  = tnew_q;
    life_d  = life_q;
    if (flush) begin
      valid_d = 1'b0;
      tnew_d  = 2'd0;
      life_d  = 2'd0;
    end else if (load) begin
      // Newest writer wins; the countdown restarts instead of decrementing this edge.
      valid_d = 1'b1;
      tnew_d  = clamp_tnew(load_tnew);
      life_d  = 2'(LIFE_INIT);
    end else if (valid_q) begin
      life_d = life_q - 2'd1;
      tnew_d = (tnew_q != 2'd0) ? tnew_q - 2'd1 : 2'd0;
      if (life_q <= 2'd1) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tnew_q  <= 2'd0;
      life_q  <= 2'd0;
    end else begin
      valid_q <= valid_d;
      tnew_q  <= tnew_d;
      life_q  <= life_d;
    end
  end

  assign valid = valid_q;
  assign tnew  = tnew_q;

endmodule

// File: rtl/grf_scoreboard.sv
// GRF hazard scoreboard: one countdown cell per register, combinational Tnew/Tuse stall
// detection and a registered busy map with its population count.
module grf_scoreboard
  import grf_scoreboard_pkg::*;
#(
  parameter int unsigned NREG      = GRF_NREG,
  parameter int unsigned LIFE_INIT = GRF_LIFE_INIT
) (
  input  logic             Clk,
  input  logic             Rst,
  grf_scoreboard_if.slave  sb
);

  logic [GRF_NREG-1:0]  valid;
  logic [1:0]           tnew [GRF_NREG];
  logic                 stall;
  logic                 issue_ok;
  logic [GRF_CNT_W-1:0] busy_cnt;

  // $0 is hardwired zero and never produces a hazard.
  assign valid[0] = 1'b0;
  assign tnew[0]  = 2'd0;

  // A stalled D-stage issues a bubble, so no entry may be created that cycle.
  assign issue_ok = sb.IssueEn && !stall && sb.IssueWr && (sb.IssueA3 != '0);

  for (genvar i = 1; i < GRF_NREG; i++) begin : g_entry
    if (i < NREG) begin : g_live
      grf_sb_entry #(
        .LIFE_INIT (LIFE_INIT)
      ) u_entry (
        .clk       (Clk),
        .rst       (Rst),
        .flush     (sb.Flush),
        .load      (issue_ok && (sb.IssueA3 == GRF_AW'(i))),
        .load_tnew (sb.IssueTnew),
        .valid     (valid[i]),
        .tnew      (tnew[i])
      );
    end else begin : g_unused
      assign valid[i] = 1'b0;
      assign tnew[i]  = 2'd0;
    end
  end

  always_comb begin
    stall = 1'b0;
    if (sb.Use1 && (sb.A1 != '0) && valid[sb.A1] && (tnew[sb.A1] > sb.Tuse1)) begin
      stall = 1'b1;
    end
    if (sb.Use2 && (sb.A2 != '0) && valid[sb.A2] && (tnew[sb.A2] > sb.Tuse2)) begin
      stall = 1'b1;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < GRF_NREG; i++) begin
      busy_cnt = busy_cnt + GRF_CNT_W'(valid[i]);
    end
  end

  assign sb.Stall   = stall;
  assign sb.Busy    = valid;
  assign sb.BusyCnt = busy_cnt;

endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed bench for grf_scoreboard: an age-based reference model checked every cycle,
// plus literal expectations for the load-use, ALU-chain, $0, overwrite, flush and reset cases.
module tb_grf_scoreboard;
  import grf_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  grf_scoreboard_if sb_if ();

  grf_scoreboard dut (
    .Clk (clk),
    .Rst (rst),
    .sb  (sb_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int now   = 0;
  bit running = 1'b1;

  // Model: an entry is the edge index at which its writer issued plus the issued Tnew.
  int iss_t  [32];
  int iss_tn [32];
  bit alive  [32];

  function automatic bit m_valid(input int r);
    return alive[r] && ((now - iss_t[r]) < 3);
  endfunction

  function automatic int m_tnew(input int r);
    int t;
    if (!m_valid(r)) return 0;
    t = ((iss_tn[r] > 2) ? 2 : iss_tn[r]) - (now - iss_t[r]);
    return (t < 0) ? 0 : t;
  endfunction

  function automatic bit m_hazard(input logic u, input logic [4:0] a, input logic [1:0] tu);
    return u && (a != 5'd0) && m_valid(int'(a)) && (m_tnew(int'(a)) > int'(tu));
  endfunction

  function automatic bit m_stall();
    return m_hazard(sb_if.Use1, sb_if.A1, sb_if.Tuse1) ||
           m_hazard(sb_if.Use2, sb_if.A2, sb_if.Tuse2);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    sb_if.IssueEn = 1'b0; sb_if.IssueWr = 1'b0; sb_if.IssueA3 = '0; sb_if.IssueTnew = '0;
    sb_if.A1 = '0; sb_if.A2 = '0; sb_if.Tuse1 = '0; sb_if.Tuse2 = '0;
    sb_if.Use1 = 1'b0; sb_if.Use2 = 1'b0; sb_if.Flush = 1'b0;
  endtask

  task automatic issue(input int a3, input int t);
    sb_if.IssueEn = 1'b1; sb_if.IssueWr = 1'b1;
    sb_if.IssueA3 = 5'(a3); sb_if.IssueTnew = 2'(t);
  endtask

  task automatic read1(input int a, input int tu);
    sb_if.Use1 = 1'b1; sb_if.A1 = 5'(a); sb_if.Tuse1 = 2'(tu);
  endtask

  task automatic read2(input int a, input int tu);
    sb_if.Use2 = 1'b1; sb_if.A2 = 5'(a); sb_if.Tuse2 = 2'(tu);
  endtask

  // Advance one clock edge, applying the same edge to the model with the held inputs.
  task automatic tick();
    bit s;
    int r;
    s = m_stall();
    @(posedge clk);
    now++;
    if (rst || sb_if.Flush) begin
      for (int i = 0; i < 32; i++) alive[i] = 1'b0;
    end else if (sb_if.IssueEn && !s && sb_if.IssueWr && (sb_if.IssueA3 != 5'd0)) begin
      r = int'(sb_if.IssueA3);
      alive[r]  = 1'b1;
      iss_t[r]  = now;
      iss_tn[r] = int'(sb_if.IssueTnew);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (running) begin
      logic [31:0] eb;
      int ec;
      eb = '0;
      ec = 0;
      for (int i = 0; i < 32; i++) begin
        eb[i] = m_valid(i);
        ec += int'(m_valid(i));
      end
      check("model_stall", longint'(sb_if.Stall), longint'(m_stall()));
      check("model_busy", longint'(sb_if.Busy), longint'(eb));
      check("model_busycnt", longint'(sb_if.BusyCnt), longint'(ec));
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      alive[i] = 1'b0; iss_t[i] = 0; iss_tn[i] = 0;
    end
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy", longint'(sb_if.Busy), 0);
    check("rst_cnt", longint'(sb_if.BusyCnt), 0);
    check("rst_stall", longint'(sb_if.Stall), 0);

    // Load-use on $5
    issue(5, 2); tick();
    idle(); read1(5, 1); #1;
    check("lu_stall", longint'(sb_if.Stall), 1);
    check("lu_busy5", longint'(sb_if.Busy[5]), 1);
    tick(); #1;
    check("lu_stall_gone", longint'(sb_if.Stall), 0);
    tick(); #1;
    check("lu_busy5_age2", longint'(sb_if.Busy[5]), 1);
    tick(); #1;
    check("lu_busy5_clr", longint'(sb_if.Busy[5]), 0);

    // ALU chain on $8
    idle(); issue(8, 1); tick();
    idle(); read2(8, 1); #1;
    check("alu_nostall", longint'(sb_if.Stall), 0);
    read2(8, 0); #1;
    check("alu_stall", longint'(sb_if.Stall), 1);
    tick(); #1;
    check("alu_stall_one", longint'(sb_if.Stall), 0);
    idle(); tick(); tick();

    // $0 never tracked
    issue(0, 2); tick();
    idle(); read1(0, 0); #1;
    check("r0_stall", longint'(sb_if.Stall), 0);
    check("r0_busy", longint'(sb_if.Busy), 0);
    check("r0_cnt", longint'(sb_if.BusyCnt), 0);

    // Overwrite of $3
    idle(); issue(3, 0); tick();
    issue(3, 2); tick();
    idle(); read1(3, 1); #1;
    check("ow_tnew2_stall", longint'(sb_if.Stall), 1);
    tick(); #1;
    check("ow_busy3_a1", longint'(sb_if.Busy[3]), 1);
    tick(); #1;
    check("ow_busy3_a2", longint'(sb_if.Busy[3]), 1);
    tick(); #1;
    check("ow_busy3_clr", longint'(sb_if.Busy[3]), 0);

    // Flush beats a simultaneous issue
    idle(); issue(4, 1); tick();
    issue(6, 1); tick(); #1;
    check("fl_cnt_before", longint'(sb_if.BusyCnt), 2);
    issue(7, 2); sb_if.Flush = 1'b1; read1(7, 0); tick();
    sb_if.Flush = 1'b0; sb_if.IssueEn = 1'b0; #1;
    check("fl_busy", longint'(sb_if.Busy), 0);
    check("fl_cnt", longint'(sb_if.BusyCnt), 0);
    check("fl_stall", longint'(sb_if.Stall), 0);

    // Reset mid-countdown drops entries and the concurrent issue
    idle(); issue(1, 2); tick();
    issue(2, 2); tick();
    issue(9, 2); tick();
    idle(); #1;
    check("rs_cnt_before", longint'(sb_if.BusyCnt), 3);
    rst = 1'b1; issue(10, 2); tick();
    rst = 1'b0; idle(); read1(9, 0); #1;
    check("rs_busy", longint'(sb_if.Busy), 0);
    check("rs_cnt", longint'(sb_if.BusyCnt), 0);
    check("rs_stall", longint'(sb_if.Stall), 0);

    // Mixed sweep, checked by the model each cycle
    for (int i = 0; i < 48; i++) begin
      idle();
      issue((i * 7 + 3) % 32, i % 4);
      sb_if.IssueWr = ((i % 5) != 0);
      read1((i * 3) % 32, i % 3);
      read2((i * 11 + 1) % 32, (i + 1) % 4);
      sb_if.Use2 = ((i % 2) != 0);
      sb_if.Flush = (i == 30);
      tick();
    end
    idle();
    repeat (4) tick();

    running = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grf_scoreboard.md
GRF_SCOREBOARD -- requirements
Module: grf_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of tracked GRF registers (address width 5).
REQ-002 SHALL have parameter LIFE_INIT, default 3, number of in-flight stages after issue (E, M, W).
REQ-003 SHALL have port Clk, input, 1 bit, single system clock; all state updates on rising edge.
REQ-004 SHALL have port Rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port IssueEn, input, 1 bit, D-stage instruction advances into E on this edge.
REQ-006 SHALL have port IssueWr, input, 1 bit, the issuing instruction writes the GRF.
REQ-007 SHALL have port IssueA3, input, 5 bits, destination register of the issuing instruction.
REQ-008 SHALL have port IssueTnew, input, 2 bits, cycles after E entry until the result is forwardable.
REQ-009 SHALL have ports A1/A2, input, 5 bits each, source registers of the current D-stage instruction.
REQ-010 SHALL have ports Tuse1/Tuse2, input, 2 bits each, cycles until A1/A2 are consumed.
REQ-011 SHALL have ports Use1/Use2, input, 1 bit each, A1/A2 are actually read.
REQ-012 SHALL have port Flush, input, 1 bit, discard all in-flight entries.
REQ-013 SHALL have port Stall, output, 1 bit, freeze F/D and insert an E bubble.
REQ-014 SHALL have port Busy, output, 32 bits, bit i set while register i has a valid entry.
REQ-015 SHALL have port BusyCnt, output, 6 bits, population count of Busy.

Function
REQ-016 SHALL hold per-register state: valid, tnew (2 bits), life (2 bits); register 0 SHALL never become valid.
REQ-017 SHALL drive Stall combinationally in the same cycle: for k=1,2, set when Usek && Ak!=0 && valid[Ak] && tnew[Ak] > Tusek.
REQ-018 SHALL ignore IssueEn while Stall=1 (bubble issued, no entry created).
REQ-019 SHALL, on an accepted issue with IssueWr=1 and IssueA3!=0, load entry IssueA3 with valid=1, life=LIFE_INIT, tnew=min(IssueTnew,2).
REQ-020 SHALL decrement every valid entry's life and tnew on each edge, saturating tnew at 0, regardless of Stall.
REQ-021 SHALL clear valid when life decrements from 1 to 0, so an entry lives exactly 3 cycles after issue.
REQ-022 SHALL, when an issue targets a register whose entry is already valid, let the new issue overwrite it (newest writer wins; decrement not applied that edge).
REQ-023 SHALL, on Flush=1, clear all valid bits on that edge; Flush SHALL take priority over a simultaneous issue.
REQ-024 SHALL derive Busy and BusyCnt from registered state only (no same-cycle issue visibility).
REQ-025 SHALL guarantee tnew=0 for any entry with life=1 (W stage), given the clamp in REQ-019.

Reset
REQ-026 SHALL, when Rst=1 at an edge, clear all valid/tnew/life; Stall=0, Busy=0, BusyCnt=0 from the next cycle.
REQ-027 SHALL give Rst priority over Flush and IssueEn; a reset mid-countdown discards all entries.
REQ-028 SHALL start from the all-clear state at simulation time zero before the first reset.

Structure
REQ-029 SHALL place LIFE_INIT, TNEW_MAX=2 and the register-count constant in the shared CPU constants package.
REQ-030 SHALL instantiate one sub-module grf_sb_entry per register (valid/tnew/life countdown cell), generated 1..31.
REQ-031 SHALL compute Stall and BusyCnt in the top level from the entry outputs.

Verification
REQ-032 SHALL verify load-use: issue $5 Tnew=2, then D reads A1=5 Tuse1=1 -> Stall=1 one cycle, then 0; Busy[5] clears 3 cycles after issue.
REQ-033 SHALL verify no-stall ALU chain: issue $8 Tnew=1, D reads A2=8 Tuse2=1 -> Stall=0; Tuse2=0 -> Stall=1 exactly one cycle.
REQ-034 SHALL verify $0: issue IssueA3=0 Tnew=2, read A1=0 Tuse1=0 -> Stall=0, Busy=0, BusyCnt=0.
REQ-035 SHALL verify overwrite: issue $3 Tnew=0, next cycle issue $3 Tnew=2 -> tnew[3]=2, life=3, Busy[3] held 3 further cycles.
REQ-036 SHALL verify Flush with simultaneous issue of $7 while $4,$6 busy -> next cycle Busy=0, BusyCnt=0, Stall=0.
REQ-037 SHALL verify mid-operation reset: three registers busy, Rst pulsed one cycle -> all outputs 0 next cycle; an issue during Rst is dropped.
